yacc_access_sequencer: RTL

Single-request-at-a-time access controller for the YACC compressed L2 data path. It takes one address from the requester, runs a tag lookup on the compressed cache array, and on a miss fetches the 64-byte block from memory and classifies its compression factor (CF). It then issues the fill write to the array and returns the uncompressed block to the requester. It sits between the upper-level requester and the cache array / memory model, and owns all sequencing and the hit/miss statistics.

---
 rtl/yacc_pkg.sv | 37 +++
 rtl/yacc_cf_classifier.sv | 22 ++
 rtl/yacc_access_sequencer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/yacc_pkg.sv
// Shared definitions for the YACC compressed L2 access path: compression-factor
// encodings, block geometry, address field positions and the sequencer state set.
package yacc_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 512;
    localparam int BLOCK_BYTES = 64;
    localparam int OFFSET_W    = $clog2(BLOCK_BYTES);

    // Request address layout: tag | set index | block id within super-block | byte offset.
    localparam int TAG_MSB    = 31;
    localparam int TAG_LSB    = 11;
    localparam int INDEX_MSB  = 10;
    localparam int INDEX_LSB  = 8;
    localparam int BLKID_MSB  = 7;
    localparam int BLKID_LSB  = 6;
    localparam int OFFSET_MSB = 5;
    localparam int OFFSET_LSB = 0;

    typedef enum logic [1:0] {
        CF_NONE    = 2'b00,
        CF_HALF    = 2'b01,
        CF_QUARTER = 2'b10,
        CF_RSVD    = 2'b11
    } cf_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_CHECK,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_FILL,
        ST_RESP
    } state_e;

endpackage

// File: rtl/yacc_cf_classifier.sv
// Compression-factor classifier: a block whose upper three quarters are zero packs
// four to a line, upper half zero packs two, anything else stays uncompressed.
module yacc_cf_classifier
    import yacc_pkg::*;
#(
    parameter int DATA_W = DATA_WIDTH
) (
    // Only the upper three quarters decide the class; the low quarter never matters.
    input  logic [DATA_W-1:DATA_W/4] data_i,
    output logic [1:0]               cf_o
);

    always_comb begin
        cf_o = CF_NONE;
        if (data_i[DATA_W-1:DATA_W/4] == '0) begin
            cf_o = CF_QUARTER;
        end else if (data_i[DATA_W-1:DATA_W/2] == '0) begin
            cf_o = CF_HALF;
        end
    end

endmodule

// File: rtl/yacc_access_sequencer.sv
// One-request-at-a-time sequencer: tag lookup, miss fetch with CF classification,
// fill write to the compressed array and block return, plus hit/miss statistics.
module yacc_access_sequencer
    import yacc_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DATA_W = DATA_WIDTH
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,

    output logic              lookup_valid,
    output logic [ADDR_W-1:0] lookup_addr,
    input  logic              lookup_hit,
    input  logic [DATA_W-1:0] lookup_data,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,

    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic [1:0]        fill_cf,
    input  logic              fill_done,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_hit,

    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    cf_e               cf_q, cf_d;
    logic              rsp_hit_q, rsp_hit_d;
    logic [31:0]       hit_count_q, hit_count_d;
    logic [31:0]       miss_count_q, miss_count_d;

    logic              req_ready_q, lookup_valid_q, mem_req_valid_q, fill_valid_q, rsp_valid_q;
    logic [1:0]        cf_class;

    yacc_cf_classifier #(.DATA_W(DATA_W)) u_cf_classifier (
        .data_i (mem_rsp_data[DATA_W-1:DATA_W/4]),
        .cf_o   (cf_class)
    );

    always_comb begin
        // NOTE: every target gets its hold value first, so no branch can infer a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        data_d       = data_q;
        cf_d         = cf_q;
        rsp_hit_d    = rsp_hit_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: state_d = ST_CHECK;
            ST_CHECK: begin
                if (lookup_hit) begin
                    data_d    = lookup_data;
                    rsp_hit_d = 1'b1;
                    if (hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
                    state_d   = ST_RESP;
                end else begin
                    rsp_hit_d = 1'b0;
                    if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
                    state_d   = ST_MEM_REQ;
                end
            end
            ST_MEM_REQ: begin
                if (mem_req_ready) state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (mem_rsp_valid) begin
                    data_d  = mem_rsp_data;
                    cf_d    = cf_e'(cf_class);
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (fill_done) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so every output leaves a flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: address/data registers are plain flops and are cleared with everything else.
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            data_q          <= '0;
            cf_q            <= CF_NONE;
            rsp_hit_q       <= 1'b0;
            hit_count_q     <= '0;
            miss_count_q    <= '0;
            req_ready_q     <= 1'b1;
            lookup_valid_q  <= 1'b0;
            mem_req_valid_q <= 1'b0;
            fill_valid_q    <= 1'b0;
            rsp_valid_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples values from before this edge.
            state_q         <= state_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            cf_q            <= cf_d;
            rsp_hit_q       <= rsp_hit_d;
            hit_count_q     <= hit_count_d;
            miss_count_q    <= miss_count_d;
            req_ready_q     <= (state_d == ST_IDLE);
            lookup_valid_q  <= (state_d == ST_LOOKUP);
            mem_req_valid_q <= (state_d == ST_MEM_REQ);
            fill_valid_q    <= (state_d == ST_FILL);
            rsp_valid_q     <= (state_d == ST_RESP);
        end
    end

    assign req_ready     = req_ready_q;
    assign lookup_valid  = lookup_valid_q;
    assign lookup_addr   = addr_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign fill_valid    = fill_valid_q;
    assign fill_addr     = addr_q;
    assign fill_data     = data_q;
    assign fill_cf       = cf_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = data_q;
    assign rsp_hit       = rsp_hit_q;
    assign hit_count     = hit_count_q;
    assign miss_count    = miss_count_q;

endmodule
